// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch, decode, address, memory, execute,
// writeback and branch states driving datapath strobes.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   run                   fetch/execute enable, sampled at boundaries
//   opcode                IR opcode field, used in DECODE
//   mem_ready             memory handshake acknowledge
//   change_pc             branch-taken flag from the ALU
//   alu_opcode, alu_src_b ALU operation and B-operand select
//   mem_read, mem_write   memory strobes
//   ir_write, pc_inc      IR load and PC increment
//   pc_branch             PC load of branch target
//   reg_write, mem_to_reg register write enable and writeback select
//   state                 current state encoding
//   retired               completed-instruction counter
module multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [2:0]          opcode,
    input  logic                mem_ready,
    input  logic                change_pc,
    output logic [2:0]          alu_opcode,
    output logic                alu_src_b,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_inc,
    output logic                pc_branch,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        ADDR    = 4'd3,
        MEM     = 4'd4,
        LOAD_WB = 4'd5,
        EXEC    = 4'd6,
        ALU_WB  = 4'd7,
        BRANCH  = 4'd8
    } state_e;

    localparam logic [2:0] OP_ADD = 3'b100;

    // Kept as raw bits so the unused codes 9-15 stay representable
    logic [3:0]          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 3'b000;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        retired_d  = retired_q;
        done       = 1'b0;
        alu_opcode = OP_ADD;
        alu_src_b  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                op_d = opcode;
                if (opcode[2])      state_d = EXEC;
                else if (opcode[1]) state_d = BRANCH;
                else                state_d = ADDR;
            end
            ADDR: begin
                alu_src_b = 1'b1;
                state_d   = MEM;
            end
            MEM: begin
                mem_read  = (op_q == 3'b000);
                mem_write = (op_q == 3'b001);
                if (mem_ready) begin
                    if (op_q == 3'b000) state_d = LOAD_WB;
                    else                done    = 1'b1;
                end
            end
            LOAD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                done       = 1'b1;
            end
            EXEC: begin
                alu_opcode = op_q;
                state_d    = ALU_WB;
            end
            ALU_WB: begin
                alu_opcode = op_q;
                reg_write  = 1'b1;
                done       = 1'b1;
            end
            BRANCH: begin
                alu_opcode = op_q;
                pc_branch  = change_pc;
                done       = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Completion is the only point besides IDLE where run is sampled
        if (done) begin
            retired_d = retired_q + RETIRE_W'(1);
            state_d   = run ? FETCH : IDLE;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: expands each instruction into
// its expected per-cycle state/strobe schedule and compares every cycle.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [2:0]    opcode;
    logic          mem_ready;
    logic          change_pc;
    logic [2:0]    alu_opcode;
    logic          alu_src_b;
    logic          mem_read;
    logic          mem_write;
    logic          ir_write;
    logic          pc_inc;
    logic          pc_branch;
    logic          reg_write;
    logic          mem_to_reg;
    logic [3:0]    state;
    logic [RW-1:0] retired;

    int total = 0;
    int bad   = 0;
    int ret_m = 0;

    multicycle_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .mem_ready(mem_ready), .change_pc(change_pc),
        .alu_opcode(alu_opcode), .alu_src_b(alu_src_b),
        .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_inc(pc_inc), .pc_branch(pc_branch),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] outs();
        return {alu_opcode, alu_src_b, mem_read, mem_write, ir_write,
                pc_inc, pc_branch, reg_write, mem_to_reg};
    endfunction

    // Expected strobes for one cycle, straight from the state table
    function automatic logic [10:0] expo(input int st, input logic [2:0] op,
                                         input logic rdy, input logic cpc);
        logic [2:0] a = 3'b100;
        logic sb = 0, mr = 0, mw = 0, ir = 0, pi = 0, pb = 0, rw = 0, mtr = 0;
        case (st)
            1: begin mr = 1; ir = rdy; pi = rdy; end
            3: sb = 1;
            4: begin mr = (op == 3'b000); mw = (op == 3'b001); end
            5: begin rw = 1; mtr = 1; end
            6: a = op;
            7: begin a = op; rw = 1; end
            8: begin a = op; pb = cpc; end
            default: ;
        endcase
        return {a, sb, mr, mw, ir, pi, pb, rw, mtr};
    endfunction

    task automatic cyc(input int st, input logic rdy, input logic cpc,
                       input logic rn, input logic [2:0] op);
        @(negedge clk);
        mem_ready = rdy;
        change_pc = cpc;
        run       = rn;
        opcode    = (st == 2) ? op : 3'($urandom);
        #1;
        chk("state", 32'(state), 32'(st));
        chk("outs", 32'(outs()), 32'(expo(st, op, rdy, cpc)));
        chk("retired", 32'(retired), 32'(ret_m % (1 << RW)));
    endtask

    // One instruction: fw/mw are wait cycles before mem_ready in FETCH/MEM;
    // keep is the run level seen at completion
    task automatic instr(input logic [2:0] op, input int fw, input int mw,
                         input logic cpc, input logic keep);
        for (int i = 0; i < fw; i++) cyc(1, 0, 1'($urandom), 1'($urandom), op);
        cyc(1, 1, 1'($urandom), 1'($urandom), op);
        if (op[2]) begin
            cyc(2, 1'($urandom), 1'($urandom), 1'($urandom), op);
            cyc(6, 1'($urandom), 1'($urandom), 1'($urandom), op);
            cyc(7, 1'($urandom), 1'($urandom), keep, op);
        end else if (op[1]) begin
            cyc(2, 1'($urandom), 1'($urandom), 1'($urandom), op);
            cyc(8, 1'($urandom), cpc, keep, op);
        end else begin
            cyc(2, 1'($urandom), 1'($urandom), 1'($urandom), op);
            cyc(3, 1'($urandom), 1'($urandom), 1'($urandom), op);
            for (int i = 0; i < mw; i++)
                cyc(4, 0, 1'($urandom), 1'($urandom), op);
            if (op == 3'b000) begin
                cyc(4, 1, 1'($urandom), 1'($urandom), op);
                cyc(5, 1'($urandom), 1'($urandom), keep, op);
            end else begin
                cyc(4, 1, 1'($urandom), keep, op);
            end
        end
        ret_m++;
        if (!keep) begin
            cyc(0, 1'($urandom), 1'($urandom), 0, op);
            cyc(0, 1'($urandom), 1'($urandom), 0, op);
            cyc(0, 1'($urandom), 1'($urandom), 1, op);
        end
    endtask

    initial begin
        rst_n = 0; run = 0; opcode = 0; mem_ready = 0; change_pc = 0;
        #3;
        chk("rst_state", 32'(state), 0);
        chk("rst_outs", 32'(outs()), 32'(expo(0, 0, 0, 0)));
        chk("rst_ret", 32'(retired), 0);
        @(negedge clk);
        rst_n = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);

        instr(3'b100, 0, 0, 0, 1);
        instr(3'b000, 0, 3, 0, 1);
        instr(3'b010, 0, 0, 1, 1);
        instr(3'b011, 1, 0, 0, 1);
        instr(3'b001, 0, 0, 0, 1);
        instr(3'b101, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++)
            instr(3'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom), ($urandom_range(0, 7) != 0));

        // Asynchronous reset in the middle of a stalled load
        cyc(1, 1, 0, 1, 3'b000);
        cyc(2, 0, 0, 1, 3'b000);
        cyc(3, 0, 0, 1, 3'b000);
        cyc(4, 0, 0, 1, 3'b000);
        #1 rst_n = 0;
        #1;
        chk("mrst_state", 32'(state), 0);
        chk("mrst_mrd", 32'(mem_read), 0);
        chk("mrst_outs", 32'(outs()), 32'(expo(0, 0, 0, 0)));
        chk("mrst_ret", 32'(retired), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
